// File: rtl/eth_tx_frame_sequencer_pkg.sv
// Shared types, frame constants and the CRC-32 byte update for the
// Ethernet transmit frame sequencer.
package eth_tx_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } tx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNDERRUN = 2'b01,
        ERR_OVERSIZE = 2'b10
    } tx_err_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int MIN_FRAME_SIZE = 64;
    localparam int MAX_FRAME_SIZE = 1518;
    localparam int FCS_BYTES      = 4;
    localparam int MIN_DATA_BYTES = MIN_FRAME_SIZE - FCS_BYTES;
    localparam int MAX_DATA_BYTES = MAX_FRAME_SIZE - FCS_BYTES;

    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
    // Good-frame residue written MSB-first; the reflected register holds
    // its bit reverse (0xDEBB20E3) after data+FCS have been folded in.
    localparam logic [31:0] CRC32_CONSTANT = 32'hC704DD7B;

    // Fold one byte into a reflected CRC-32 register, LSB first, no inversion.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_frame_sequencer_crc32_byte_engine.sv
// Running CRC-32 register for the transmit path. Holds the reflected,
// non-inverted value; the sequencer complements it to form the FCS.
module crc32_byte_engine
    import eth_tx_frame_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    // Seed to all-ones on reset or frame start, otherwise fold in one byte when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '1;
        end else if (init) begin
            crc <= '1;
        end else if (en) begin
            crc <= crc32_update(crc, data);
        end
    end

endmodule

// File: rtl/eth_tx_frame_sequencer.sv
// Transmit MAC sequencer: preamble, SFD, data, zero pad, FCS and inter-frame
// gap on a byte-wide PHY interface, with underrun/oversize abort and drain.
// Optional build macro TX_STATS_EN adds saturating frame statistics outputs.
module eth_tx_frame_sequencer #(
    parameter int PREAMBLE_LEN   = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MIN_DATA_BYTES = eth_tx_frame_sequencer_pkg::MIN_DATA_BYTES,
    parameter int MAX_DATA_BYTES = eth_tx_frame_sequencer_pkg::MAX_DATA_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
`ifdef TX_STATS_EN
    ,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_frames_err,
    output logic [31:0] stat_pad_frames
`endif
);

    import eth_tx_frame_sequencer_pkg::*;

    tx_state_t   state, state_d;
    logic [7:0]  phase_cnt, phase_d, phase_inc;
    logic [10:0] byte_cnt, byte_d, byte_inc;
    logic [7:0]  tx_data_d;
    logic        tx_en_d, done_d, err_d, pad_entry;
    tx_err_t     err_q, err_q_d;
    logic        crc_init, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc, fcs;

    assign phase_inc = phase_cnt + 8'd1;
    assign byte_inc  = byte_cnt + 11'd1;
    assign fcs       = ~crc;
    assign busy      = (state != ST_IDLE);
    assign err_code  = err_q;

    crc32_byte_engine u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_en),
        .data  (crc_data),
        .crc   (crc)
    );

    // Next-state, next-output and CRC control decode for the frame sequencer.
    always_comb begin
        state_d   = state;
        phase_d   = phase_cnt;
        byte_d    = byte_cnt;
        tx_data_d = 8'h00;
        tx_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_q_d   = err_q;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        crc_data  = 8'h00;
        s_ready   = 1'b0;
        pad_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_PRE;
                    phase_d = '0;
                    err_q_d = ERR_NONE;
                end
            end
            ST_PRE: begin
                tx_en_d   = 1'b1;
                tx_data_d = PREAMBLE_BYTE;
                phase_d   = phase_inc;
                if (phase_cnt == 8'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                tx_en_d   = 1'b1;
                tx_data_d = SFD_BYTE;
                crc_init  = 1'b1;
                byte_d    = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                s_ready = 1'b1;
                if (!s_valid) begin
                    err_d   = 1'b1;
                    err_q_d = ERR_UNDERRUN;
                    state_d = ST_DRAIN;
                end else begin
                    tx_en_d   = 1'b1;
                    tx_data_d = s_data;
                    crc_en    = 1'b1;
                    crc_data  = s_data;
                    byte_d    = byte_inc;
                    if (s_last) begin
                        phase_d = '0;
                        if (byte_inc < 11'(MIN_DATA_BYTES)) begin
                            state_d   = ST_PAD;
                            pad_entry = 1'b1;
                        end else begin
                            state_d = ST_FCS;
                        end
                    end else if (byte_inc == 11'(MAX_DATA_BYTES)) begin
                        // The byte that reaches the limit still goes out; the frame dies after it.
                        err_d   = 1'b1;
                        err_q_d = ERR_OVERSIZE;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                byte_d  = byte_inc;
                if (byte_inc == 11'(MIN_DATA_BYTES)) begin
                    state_d = ST_FCS;
                    phase_d = '0;
                end
            end
            ST_FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = fcs[{phase_cnt[1:0], 3'b000} +: 8];
                phase_d   = phase_inc;
                if (phase_cnt == 8'd3) begin
                    done_d  = 1'b1;
                    state_d = ST_IFG;
                    phase_d = '0;
                end
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = ST_IFG;
                    phase_d = '0;
                end
            end
            ST_IFG: begin
                // The IDLE cycle that follows supplies the final idle byte-time.
                phase_d = phase_inc;
                if (phase_inc >= 8'(IFG_BYTES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered PHY-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            byte_cnt   <= '0;
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state      <= state_d;
            phase_cnt  <= phase_d;
            byte_cnt   <= byte_d;
            tx_data    <= tx_data_d;
            tx_en      <= tx_en_d;
            frame_done <= done_d;
            frame_err  <= err_d;
            err_q      <= err_q_d;
        end
    end

`ifdef TX_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Saturating counts of good, aborted and padded frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_frames_ok  <= '0;
            stat_frames_err <= '0;
            stat_pad_frames <= '0;
        end else begin
            if (done_d)    stat_frames_ok  <= sat_inc(stat_frames_ok);
            if (err_d)     stat_frames_err <= sat_inc(stat_frames_err);
            if (pad_entry) stat_pad_frames <= sat_inc(stat_pad_frames);
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_frame_sequencer.sv
// Self-checking bench for eth_tx_frame_sequencer: random frame payloads are
// pushed through the sequencer and the PHY byte stream is compared against a
// frame built from the Ethernet framing rules with a bit-serial CRC-32.
module tb_eth_tx_frame_sequencer;

    typedef logic [7:0] byte_q_t [$];

    typedef struct packed {
        logic       en;
        logic [7:0] data;
        logic       done;
        logic       err;
        logic       hs_last;
        logic [1:0] code;
    } rec_t;

    localparam int PRE_LEN = 7;
    localparam int IFG     = 12;
    localparam int MIN_D   = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
`ifdef TX_STATS_EN
    logic [31:0] stat_frames_ok, stat_frames_err, stat_pad_frames;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t log_q[$];
    bit   logging  = 1'b0;

    eth_tx_frame_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
`ifdef TX_STATS_EN
        ,
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_err (stat_frames_err),
        .stat_pad_frames (stat_pad_frames)
`endif
    );

    always #5 clk = ~clk;

    // One record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (logging) begin
            log_q.push_back('{en: tx_en, data: tx_data, done: frame_done, err: frame_err,
                              hs_last: s_valid & s_ready & s_last, code: err_code});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reflected CRC-32, all-ones seed, no final inversion.
    function automatic logic [31:0] ref_crc(input byte_q_t q);
        logic [31:0] r;
        logic        fb;
        r = '1;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ q[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return r;
    endfunction

    function automatic byte_q_t rand_frame(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic byte_q_t full_wire(input byte_q_t d);
        byte_q_t w, body;
        logic [31:0] f;
        body = d;
        while (body.size() < MIN_D) body.push_back(8'h00);
        f = ~ref_crc(body);
        for (int i = 0; i < PRE_LEN; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (body[i]) w.push_back(body[i]);
        for (int i = 0; i < 4; i++) w.push_back(f[8*i +: 8]);
        return w;
    endfunction

    function automatic byte_q_t aborted_wire(input byte_q_t d, input int k);
        byte_q_t w;
        for (int i = 0; i < PRE_LEN; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        for (int i = 0; i < k; i++) w.push_back(d[i]);
        return w;
    endfunction

    function automatic int count_done();
        int c = 0;
        foreach (log_q[i]) if (log_q[i].done) c++;
        return c;
    endfunction

    function automatic int count_err();
        int c = 0;
        foreach (log_q[i]) if (log_q[i].err) c++;
        return c;
    endfunction

    // Offer a frame byte by byte; optionally withdraw s_valid for one cycle before byte drop_at.
    task automatic send(input byte_q_t q, input int drop_at, output bit ok);
        int guard;
        ok = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            if (i == drop_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = q[i];
            s_last  = (i == q.size() - 1);
            guard   = 0;
            forever begin
                @(negedge clk);
                if (s_ready) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                guard++;
                if (guard > 200) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (!ok) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        repeat (3) @(posedge clk);
        #1;
        while (busy && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check({tag, " idle_reached"}, 32'(g < 3000), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Locate the next contiguous tx_en run from index 'from' and compare it with 'exp'.
    task automatic check_frame(input string tag, input int from, input byte_q_t exp,
                               input bit expect_done, output int first, output int last);
        int mism = 0;
        byte_q_t body;
        logic [31:0] r, rev;
        first = -1;
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i].en) begin
                first = i;
                break;
            end
        end
        check({tag, " start_found"}, 32'(first >= 0), 32'd1);
        if (first < 0) begin
            first = log_q.size();
            last  = first - 1;
        end else begin
            last = first;
            while (last + 1 < log_q.size() && log_q[last + 1].en) last++;
        end
        check({tag, " en_cycles"}, 32'(last - first + 1), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            if (first + k > last || log_q[first + k].data !== exp[k]) mism++;
        end
        check({tag, " byte_mismatches"}, 32'(mism), 32'd0);
        check({tag, " done_on_last"}, 32'(log_q[last].done), 32'(expect_done));
        if (expect_done) begin
            for (int i = first + PRE_LEN + 1; i <= last; i++) body.push_back(log_q[i].data);
            r = ref_crc(body);
            for (int b = 0; b < 32; b++) rev[b] = r[31 - b];
            check({tag, " crc_residue"}, rev, 32'hC704DD7B);
        end
    endtask

    byte_q_t d, d2;
    bit      ok;
    int      f, l, f2, l2, h, n;
    int      exp_ok = 0, exp_err = 0, exp_pad = 0;

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst tx_en", 32'(tx_en), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst s_ready", 32'(s_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err_code", 32'(err_code), 32'd0);
        check("rst pulses", 32'({frame_done, frame_err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        logging = 1'b1;

        // 60-byte frame, no padding
        log_q.delete();
        d = rand_frame(60);
        send(d, -1, ok);
        check("t1 accepted", 32'(ok), 32'd1);
        wait_idle("t1");
        check_frame("t1", 0, full_wire(d), 1'b1, f, l);
        check("t1 wire_len", 32'(l - f + 1), 32'd72);
        check("t1 done_count", 32'(count_done()), 32'd1);
        exp_ok++;

        // 10-byte frame padded to minimum
        log_q.delete();
        d = rand_frame(10);
        send(d, -1, ok);
        check("t2 accepted", 32'(ok), 32'd1);
        wait_idle("t2");
        check_frame("t2", 0, full_wire(d), 1'b1, f, l);
        check("t2 wire_len", 32'(l - f + 1), 32'd72);
        exp_ok++;
        exp_pad++;

        // Underrun after 20 bytes of a 100-byte frame, then a follow-on frame
        log_q.delete();
        d = rand_frame(100);
        send(d, 20, ok);
        check("t3 drained", 32'(ok), 32'd1);
        n  = $urandom_range(1, 80);
        d2 = rand_frame(n);
        send(d2, -1, ok);
        check("t3 next_accepted", 32'(ok), 32'd1);
        wait_idle("t3");
        check_frame("t3 abort", 0, aborted_wire(d, 20), 1'b0, f, l);
        check("t3 err_pulse_next", 32'(log_q[l + 1].err), 32'd1);
        check("t3 err_code", 32'(log_q[l + 1].code), 32'd1);
        check("t3 err_count", 32'(count_err()), 32'd1);
        check_frame("t3 next", l + 1, full_wire(d2), 1'b1, f2, l2);
        h = -1;
        for (int i = l + 1; i < f2; i++) if (log_q[i].hs_last) h = i;
        check("t3 idle_after_drain", 32'(h >= 0 && (f2 - h - 1) >= IFG), 32'd1);
        check("t3 code_held", 32'(log_q[f2 - 2].code), 32'd1);
        check("t3 code_cleared", 32'(log_q[f2].code), 32'd0);
        exp_err++;
        exp_ok++;
        if (n < MIN_D) exp_pad++;

        // 1600 bytes: oversize abort after 1514 bytes
        log_q.delete();
        d = rand_frame(1600);
        send(d, -1, ok);
        check("t4 drained", 32'(ok), 32'd1);
        wait_idle("t4");
        check_frame("t4", 0, aborted_wire(d, 1514), 1'b0, f, l);
        check("t4 err_count", 32'(count_err()), 32'd1);
        check("t4 done_count", 32'(count_done()), 32'd0);
        check("t4 err_code", 32'(log_q[log_q.size() - 1].code), 32'd2);
        exp_err++;

        // Two 64-byte frames back to back
        log_q.delete();
        d  = rand_frame(64);
        d2 = rand_frame(64);
        send(d, -1, ok);
        check("t5 a_accepted", 32'(ok), 32'd1);
        send(d2, -1, ok);
        check("t5 b_accepted", 32'(ok), 32'd1);
        wait_idle("t5");
        check_frame("t5 a", 0, full_wire(d), 1'b1, f, l);
        check_frame("t5 b", l + 1, full_wire(d2), 1'b1, f2, l2);
        check("t5 ifg_gap", 32'(f2 - l - 1), 32'(IFG));
        check("t5 done_count", 32'(count_done()), 32'd2);
        exp_ok += 2;

        // Random-length frames
        for (int k = 0; k < 3; k++) begin
            log_q.delete();
            n = $urandom_range(1, 150);
            d = rand_frame(n);
            send(d, -1, ok);
            check("rnd accepted", 32'(ok), 32'd1);
            wait_idle("rnd");
            check_frame("rnd", 0, full_wire(d), 1'b1, f, l);
            exp_ok++;
            if (n < MIN_D) exp_pad++;
        end

`ifdef TX_STATS_EN
        check("stat ok", stat_frames_ok, 32'(exp_ok));
        check("stat err", stat_frames_err, 32'(exp_err));
        check("stat pad", stat_pad_frames, 32'(exp_pad));
`endif

        // Reset while FCS byte 2 is on the wire
        log_q.delete();
        d = rand_frame(60);
        send(d, -1, ok);
        check("t6 accepted", 32'(ok), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        d2 = full_wire(d);
        check("t6 fcs_byte2", 32'({tx_en, tx_data}), 32'({1'b1, d2[PRE_LEN + 1 + 60 + 1]}));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t6 tx_en", 32'(tx_en), 32'd0);
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 s_ready", 32'(s_ready), 32'd0);
        check("t6 err_code", 32'(err_code), 32'd0);
        check("t6 no_done", 32'(count_done()), 32'd0);
        @(posedge clk); #1;
        log_q.delete();
        d = rand_frame(20);
        send(d, -1, ok);
        check("t6 new_accepted", 32'(ok), 32'd1);
        wait_idle("t6 new");
        check_frame("t6 new", 0, full_wire(d), 1'b1, f, l);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_sequencer.md
Name: eth_tx_frame_sequencer

Overview:
Transmit-side MAC sequencer. It takes a byte stream (dest/src/type/payload) from the switch egress buffer over a valid/ready handshake, and emits a complete Ethernet frame on a byte-wide PHY interface: preamble, SFD, data, zero-pad to minimum size, then FCS. It enforces the inter-frame gap and aborts on underrun or oversize. It owns and sequences the CRC-32 datapath.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD
IFG_BYTES, 12, idle byte-times after the last FCS byte
MIN_DATA_BYTES, 60, minimum header+payload bytes (MIN_FRAME_SIZE-4); shorter frames are padded
MAX_DATA_BYTES, 1514, maximum header+payload bytes (MAX_FRAME_SIZE-4)

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous reset, active-low
s_data  in  8  frame byte from egress buffer
s_valid  in  1  s_data valid
s_last  in  1  marks final data byte of the frame
s_ready  out  1  byte accepted when s_valid & s_ready
tx_data  out  8  byte to PHY, registered
tx_en  out  1  tx_data is a valid frame byte, registered
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when the last FCS byte is driven
frame_err  out  1  one-cycle pulse when a frame aborts
err_code  out  2  00 none, 01 underrun, 10 oversize; holds until the next frame start

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, tx_en=0, tx_data=0x00, s_ready=0, busy=0, pulses=0, err_code=00, counters=0, CRC=0xFFFFFFFF. Reset mid-frame truncates: tx_en=0 the cycle after the reset edge; no FCS is sent.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- Outputs are registered. The state in cycle n determines tx_data/tx_en in cycle n+1.
- IDLE: when s_valid=1, go to PRE and clear err_code. The byte is not consumed.
- PRE: drive 0x55 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: drive 0xD5 for 1 cycle. Initialise CRC to 0xFFFFFFFF and byte_cnt to 0. Go to DATA.
- DATA: s_ready=1 combinationally.
  - On handshake: tx_data<=s_data, update CRC, byte_cnt++.
  - If s_last and byte_cnt+1<MIN_DATA_BYTES, go to PAD.
  - If s_last otherwise, go to FCS.
  - If s_valid=0, the frame underruns: tx_en=0 next cycle, frame_err pulse, err_code=01, go to DRAIN.
  - If the accepted byte makes byte_cnt=MAX_DATA_BYTES and s_last=0, the frame is oversize: abort the same way with err_code=10.
- PAD: drive 0x00 and update CRC until byte_cnt=MIN_DATA_BYTES, then go to FCS.
- FCS: drive the 4 bytes of ~CRC, least-significant byte first, bit0 of each byte = transmit bit first (reflected CRC). frame_done pulses with the 4th byte. Then go to IFG.
- DRAIN: s_ready=1 and tx_en=0. Discard bytes until a handshake with s_last, then go to IFG.
- IFG: tx_en=0 for IFG_BYTES cycles. s_ready=0. Then go to IDLE.
- s_ready=0 in every state other than DATA and DRAIN.
- byte_cnt is 11 bits and never wraps: the oversize check caps it at 1514.
- CRC: reflected polynomial 0xEDB88320, initial value all-ones. The CRC over data+pad+FCS as transmitted equals the residue 0xC704DD7B.
- Minimum frame on the wire: 8+60+4=72 tx_en cycles. Back-to-back frames start their preamble at least IFG_BYTES+1 cycles after the last FCS byte.

Optional Feature:
TX_STATS_EN
- With the macro: adds outputs stat_frames_ok[31:0], stat_frames_err[31:0] and stat_pad_frames[31:0]. These are saturating counters, reset to 0, incremented on frame_done, on frame_err, and on entry to PAD respectively.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: tx_state_t enum, tx_err_t (2-bit error code), PREAMBLE_BYTE, SFD_BYTE, MIN_DATA_BYTES and MAX_DATA_BYTES derived from the frame-size constants, CRC32_POLY_REFLECTED, CRC32_CONSTANT, and a non-inverting byte-update CRC function.
- Sub-module crc32_byte_engine:
  - Inputs: clk, rst_n, init, en, data[7:0].
  - Output: crc[31:0], the running non-inverted register.
  - The sequencer complements the output for the FCS.

Test Plan:
1. 60-byte frame with s_valid held high -> tx_data is 7×0x55, 0xD5, 60 data bytes, 4 FCS bytes. tx_en high for exactly 72 cycles. The model CRC over data+FCS equals 0xC704DD7B. frame_done pulses on cycle 72.
2. 10-byte frame -> 50 bytes of 0x00 padding follow the data. Total tx_en is 72 cycles. The FCS covers the pad. stat_pad_frames=1 when TX_STATS_EN is defined.
3. s_valid dropped after byte 20 of a 100-byte frame -> tx_en=0 on the next cycle, frame_err pulse, err_code=01. The remaining 80 bytes are drained with s_ready=1. 12 idle cycles follow before the next preamble.
4. 1600 bytes with s_last only on the final byte -> 1514 data bytes sent, then abort with err_code=10. Bytes are drained through s_last and no FCS is emitted.
5. Two 64-byte frames offered back-to-back -> exactly 12 cycles with tx_en=0 between the 4th FCS byte and the next 0x55. The second frame's FCS is correct (CRC reinitialised).
6. rst_n low for 1 cycle during FCS byte 2 -> next cycle tx_en=0, busy=0, s_ready=0, err_code=00. A new frame offered 1 cycle later starts a clean preamble.
